// File: rtl/clk_ratio_meter.sv
`default_nettype none
// clk_ratio_meter: measures the period of an asynchronous input in clk cycles,
// reported in 16.8 fixed point as the total cycle count over 2^FRAC_BITS periods.
module clk_ratio_meter #(
  parameter int INT_BITS     = 16,
  parameter int FRAC_BITS    = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_sig,
  output logic [INT_BITS+FRAC_BITS-1:0] div_out,
  output logic                          valid,
  output logic                          busy,
  output logic                          timeout
);

  localparam int W = INT_BITS + FRAC_BITS;
  localparam logic [FRAC_BITS:0]    LAST_EDGE = (FRAC_BITS+1)'((2**FRAC_BITS) - 1);
  localparam logic [W-1:0]          ACC_MAX   = '1;
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEASURE   = 2'd2,
    DONE_FAIL = 2'd3
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    edge_reg;
  logic                    rise;
  logic [W-1:0]            acc;
  logic [FRAC_BITS:0]      edge_cnt;
  logic [TIMEOUT_BITS-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], in_sig};
      edge_reg <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~edge_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_out  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      acc      <= '0;
      edge_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            busy    <= 1'b1;
            valid   <= 1'b0;
            timeout <= 1'b0;
            to_cnt  <= '0;
          end
        end
        ARM: begin
          to_cnt <= to_cnt + 1'b1;
          if (rise) begin
            state    <= MEASURE;
            acc      <= '0;
            edge_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state <= DONE_FAIL;
            busy  <= 1'b0;
          end
        end
        MEASURE: begin
          acc <= acc + 1'b1;
          // Overflow wins over a coincident final edge: the sum would wrap.
          if (acc == ACC_MAX) begin
            state <= DONE_FAIL;
            busy  <= 1'b0;
          end else if (rise) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == LAST_EDGE) begin
              div_out <= acc + 1'b1;
              valid   <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DONE_FAIL: begin
          div_out <= '1;
          timeout <= 1'b1;
          valid   <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
- Measures the period of an external, asynchronous pulse/clock input (`in_sig`) in units of `clk` cycles.
- Reports the period in the same 16.8 fixed-point format the PIO clock divider consumes, so `div_out` can be written straight into a divider's `div` register to reproduce the measured rate.
- It is the inverse of the divider: the divider turns a divisor into a rate; this block turns a rate into a divisor.
- Used for PIO clock calibration and for self-checking divider output in the bench.

Parameters:
- INT_BITS, 16, integer bits of result.
- FRAC_BITS, 8, fractional bits of result; measurement window = 2^FRAC_BITS input periods.
- SYNC_STAGES, 2, flip-flops in the `in_sig` synchronizer (≥2).
- TIMEOUT_BITS, 24, width of the ARM-state no-edge timeout counter; timeout after 2^TIMEOUT_BITS − 1 cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a measurement
- in_sig  input  1  asynchronous signal to measure; rising edges counted
- div_out  output  INT_BITS+FRAC_BITS  measured period, 16.8 fixed point, clk cycles per in_sig period
- valid  output  1  high while div_out holds a completed measurement
- busy  output  1  high in ARM or MEASURE
- timeout  output  1  high while last measurement failed (no edge or overflow)

Behaviour:
- Reset: state IDLE; div_out=0, valid=0, busy=0, timeout=0; synchronizer flops, edge register, accumulator, edge counter, timeout counter all 0.
- Synchronizer: `in_sig` passes through SYNC_STAGES flops, then one edge register.
- rise = sync_out & ~edge_reg; one-cycle strobe, SYNC_STAGES+1 cycles after the pin edge.
- Input constraint: high and low phases ≥2 clk cycles each (period ≥4). Shorter pulses are not required to be counted.
- IDLE:
  - busy=0.
  - start=1 → ARM next cycle; clears valid and timeout; timeout counter cleared to 0.
- ARM:
  - busy=1; timeout counter increments each cycle.
  - rise → MEASURE; accumulator ← 0; edge counter ← 0.
  - Timeout counter reaches all-ones with no rise → DONE_FAIL.
- MEASURE:
  - busy=1; accumulator increments by 1 every cycle.
  - On the cycle rise is seen, the increment is still applied and edge counter increments.
  - With constant period P, accumulator = k·P at the k-th rise.
  - Rise that makes edge counter = 2^FRAC_BITS → div_out ← accumulator+1 (the incremented value), state IDLE, valid=1 next cycle.
  - If accumulator is all-ones and would increment → DONE_FAIL (overflow: integer period > 2^INT_BITS−1).
- DONE_FAIL: one cycle; div_out ← all-ones, timeout ← 1, valid ← 0, then IDLE.
- Result format: div_out[23:8] integer cycles, div_out[7:0] fraction; equals the total cycle count over 256 periods, with no division.
- Output lifetime: valid and timeout are levels, held until the next accepted start. div_out holds its value until overwritten.
- Start while busy: ignored, no restart.
- Start in the same cycle a measurement completes: ignored (state is not IDLE that cycle).
- Reset mid-operation: immediate return to IDLE with all outputs 0; the partial result is discarded.
- in_sig already high at start: no rise until the next genuine rising edge; the level itself is not counted.
- Latency: from the last counted pin rising edge to valid=1 is SYNC_STAGES+2 clk cycles.

Test Plan:
- Reset then idle: no start, toggle in_sig period 10 → div_out=0x000000, valid=0, busy=0, timeout=0 throughout.
- Integer period: in_sig 5 high/5 low, pulse start → busy=1 until completion, valid=1, div_out=0x000A00, timeout=0; valid stays high 100 cycles later.
- Fractional period: in_sig periods alternating 10 and 11 cycles (each phase ≥5), start → div_out=0x000A80 (2688); also period 4 (2/2) → div_out=0x000400.
- Timeout: TIMEOUT_BITS=8, in_sig held low, start → after 255 ARM cycles timeout=1, valid=0, div_out=0xFFFFFF, busy=0. Overflow: INT_BITS=4, FRAC_BITS=4, period 20 → timeout=1, div_out=0xFF.
- Start while busy: start at cycle 3 of MEASURE with period 10 → result unchanged (0x000A00), completes at the original time.
- Reset mid-MEASURE: assert reset 100 cycles into measurement → outputs all 0 immediately. New start after release with period 12 → div_out=0x000C00.
